// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem ready handshake,
// IF/ID pipeline register and a stuck-memory watchdog. Define IF_STAGE_PERF_EN for perf counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic [1:0]  PC_Mux_select,
  input  logic        IF_ID_Stall,
  input  logic        IF_ID_Flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cnt,
`endif
  output logic        fetch_error
);

  localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state_q;
  logic          imem_req_q;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          fetch_error_q;
  logic [31:0]   if_id_pc_q;
  logic [31:0]   if_id_instr_q;
  logic          if_id_valid_q;
  logic          fetch_done;
  logic          redirect;

  always_comb begin
    fetch_done = (state_q != ST_BOOT) && imem_ready;
    redirect   = PC_Write && ((PC_Mux_select == 2'b01) || (PC_Mux_select == 2'b10));

    pc_d = pc_q;
    if (PC_Write) begin
      case (PC_Mux_select)
        2'b00:   if (fetch_done) pc_d = pc_q + 32'd4;
        2'b01:   pc_d = branch_target;
        2'b10:   pc_d = jump_target;
        default: pc_d = pc_q;
      endcase
    end

    // Counts consecutive unanswered fetch cycles; any completion or redirect restarts it.
    wait_cnt_d = '0;
    if ((state_q != ST_BOOT) && !imem_ready && !redirect) begin
      wait_cnt_d = (wait_cnt_q == TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      imem_req_q    <= 1'b0;
      pc_q          <= RESET_PC;
      wait_cnt_q    <= '0;
      fetch_error_q <= 1'b0;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= 32'd0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      if (wait_cnt_d == TIMEOUT_C) fetch_error_q <= 1'b1;

      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          imem_req_q <= 1'b1;
        end
        ST_RUN, ST_WAIT: begin
          state_q    <= (redirect || imem_ready) ? ST_RUN : ST_WAIT;
          imem_req_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_BOOT;
          imem_req_q <= 1'b0;
        end
      endcase

      // A stalled completion is deliberately dropped; the hazard unit refetches it.
      if (IF_ID_Flush) begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= 32'd0;
        if_id_pc_q    <= 32'd0;
      end else if (!IF_ID_Stall) begin
        if (fetch_done) begin
          if_id_valid_q <= 1'b1;
          if_id_instr_q <= imem_rdata;
          if_id_pc_q    <= pc_q + 32'd4;
        end else begin
          if_id_valid_q <= 1'b0;
          if_id_instr_q <= 32'd0;
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign IF_ID_PC    = if_id_pc_q;
  assign IF_ID_Instr = if_id_instr_q;
  assign IF_ID_Valid = if_id_valid_q;
  assign fetch_error = fetch_error_q;

`ifdef IF_STAGE_PERF_EN
  logic [2:0] perf_inc;

  assign perf_inc = {state_q == ST_WAIT, IF_ID_Flush, IF_ID_Stall && !IF_ID_Flush};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      logic [31:0] cnt_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= 32'd0;
        end else if (perf_inc[gi]) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_stall_cnt = g_perf[0].cnt_q;
  assign perf_flush_cnt = g_perf[1].cnt_q;
  assign perf_wait_cnt  = g_perf[2].cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scoreboard of per-cycle expected outputs from a reference model,
// plus directed checks of the fetch, stall, redirect, wait, watchdog and wrap scenarios.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write;
  logic [1:0]  PC_Mux_select;
  logic        IF_ID_Stall;
  logic        IF_ID_Flush;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic        fetch_error;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  assign imem_rdata = word_at(imem_addr);

  if_stage #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Write      (PC_Write),
    .PC_Mux_select (PC_Mux_select),
    .IF_ID_Stall   (IF_ID_Stall),
    .IF_ID_Flush   (IF_ID_Flush),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .IF_ID_PC      (IF_ID_PC),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_Valid   (IF_ID_Valid),
`ifdef IF_STAGE_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_wait_cnt (perf_wait_cnt),
`endif
    .fetch_error   (fetch_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic [31:0] ps;
    logic [31:0] pf;
    logic [31:0] pw;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: 0 boot, 1 run, 2 wait
  int          m_state;
  int          m_cnt;
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_ps, m_pf, m_pw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic pw, input logic [1:0] sel, input logic st,
                      input logic fl, input logic [31:0] bt, input logic [31:0] jt, input logic rdy);
    exp_t        e;
    logic        fc;
    logic        redir;
    logic [31:0] pc_n;
    int          cnt_n;
    rst = r; PC_Write = pw; PC_Mux_select = sel; IF_ID_Stall = st; IF_ID_Flush = fl;
    branch_target = bt; jump_target = jt; imem_ready = rdy;

    if (r) begin
      m_state = 0; m_cnt = 0; m_pc = RST_PC; m_ifpc = 0; m_instr = 0;
      m_valid = 0; m_err = 0; m_ps = 0; m_pf = 0; m_pw = 0;
    end else begin
      fc    = (m_state != 0) && rdy;
      redir = pw && (sel == 2'd1 || sel == 2'd2);
      pc_n  = m_pc;
      if (pw) begin
        if (sel == 2'd1)            pc_n = bt;
        else if (sel == 2'd2)       pc_n = jt;
        else if (sel == 2'd0 && fc) pc_n = m_pc + 32'd4;
      end
      if (st && !fl)     m_ps = m_ps + 1;
      if (fl)            m_pf = m_pf + 1;
      if (m_state == 2)  m_pw = m_pw + 1;
      if (fl) begin
        m_valid = 0; m_instr = 0; m_ifpc = 0;
      end else if (!st) begin
        if (fc) begin
          m_valid = 1; m_instr = word_at(m_pc); m_ifpc = m_pc + 32'd4;
        end else begin
          m_valid = 0; m_instr = 0;
        end
      end
      if (m_state != 0 && !rdy && !redir) cnt_n = (m_cnt < TMO) ? m_cnt + 1 : TMO;
      else                                cnt_n = 0;
      if (cnt_n == TMO) m_err = 1;
      m_state = (m_state == 0 || redir || rdy) ? 1 : 2;
      m_cnt   = cnt_n;
      m_pc    = pc_n;
    end

    e.addr = m_pc; e.req = (m_state != 0); e.ifpc = m_ifpc; e.instr = m_instr;
    e.valid = m_valid; e.err = m_err; e.ps = m_ps; e.pf = m_pf; e.pw = m_pw;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("addr",  imem_addr, e.addr);
      check_eq("req",   32'(imem_req), 32'(e.req));
      check_eq("valid", 32'(IF_ID_Valid), 32'(e.valid));
      check_eq("instr", IF_ID_Instr, e.instr);
      if (e.valid) check_eq("ifpc", IF_ID_PC, e.ifpc);
      check_eq("err",   32'(fetch_error), 32'(e.err));
`ifdef IF_STAGE_PERF_EN
      check_eq("perf_stall", perf_stall_cnt, e.ps);
      check_eq("perf_flush", perf_flush_cnt, e.pf);
      check_eq("perf_wait",  perf_wait_cnt,  e.pw);
`endif
    end
    @(negedge clk);
  endtask

  task automatic run(input logic rdy);
    step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  initial begin
    rst = 1'b1; PC_Write = 1'b0; PC_Mux_select = 2'b00; IF_ID_Stall = 1'b0; IF_ID_Flush = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0; imem_ready = 1'b1;
    @(negedge clk);

    // Reset and sequential fetch
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", 32'(IF_ID_Valid), 32'd0);
    run(1'b1);
    check_eq("boot_req", 32'(imem_req), 32'd1);
    check_eq("boot_addr", imem_addr, 32'h0);
    run(1'b1);
    check_eq("a0_instr", IF_ID_Instr, word_at(32'h0));
    check_eq("a0_pc", IF_ID_PC, 32'h4);
    check_eq("a0_valid", 32'(IF_ID_Valid), 32'd1);
    check_eq("a1_addr", imem_addr, 32'h4);
    run(1'b1);
    check_eq("a2_addr", imem_addr, 32'h8);

    // Load-use stall at PC=8
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    check_eq("stall_pc", IF_ID_PC, 32'h8);
    check_eq("stall_instr", IF_ID_Instr, word_at(32'h4));
    check_eq("stall_addr", imem_addr, 32'h8);
    run(1'b1);
    check_eq("post_stall_pc", IF_ID_PC, 32'hC);
    check_eq("post_stall_instr", IF_ID_Instr, word_at(32'h8));

    // Branch with flush
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h40, 32'd0, 1'b1);
    check_eq("br_valid", 32'(IF_ID_Valid), 32'd0);
    check_eq("br_addr", imem_addr, 32'h40);
    run(1'b1);
    check_eq("br_ifpc", IF_ID_PC, 32'h44);

    // Memory wait at 0x10
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'd0, 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run(1'b0);
      check_eq("wait_valid", 32'(IF_ID_Valid), 32'd0);
      check_eq("wait_addr", imem_addr, 32'h10);
    end
    run(1'b1);
    check_eq("wait_done_pc", IF_ID_PC, 32'h14);
    check_eq("wait_done_valid", 32'(IF_ID_Valid), 32'd1);

    // Watchdog
    for (int i = 0; i < TMO; i++) begin
      run(1'b0);
      check_eq("wd_err", 32'(fetch_error), (i == TMO - 1) ? 32'd1 : 32'd0);
    end
    run(1'b1);
    run(1'b1);
    check_eq("wd_sticky", 32'(fetch_error), 32'd1);

    // PC wrap
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC, 1'b1);
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    run(1'b1);
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_ifpc", IF_ID_PC, 32'h0);

    // Reset clears sticky error; then jump during WAIT with stall+flush
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check_eq("rst2_err", 32'(fetch_error), 32'd0);
    check_eq("rst2_addr", imem_addr, 32'h0);
    run(1'b1);
    run(1'b1);
    for (int i = 0; i < 10; i++) run(1'b0);
    step(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 32'd0, 32'h100, 1'b0);
    check_eq("sf_valid", 32'(IF_ID_Valid), 32'd0);
    check_eq("sf_ifpc", IF_ID_PC, 32'h0);
    check_eq("sf_addr", imem_addr, 32'h100);
`ifdef IF_STAGE_PERF_EN
    check_eq("sf_perf_flush", perf_flush_cnt, 32'd1);
`endif
    for (int i = 0; i < TMO; i++) begin
      run(1'b0);
      check_eq("wd2_err", 32'(fetch_error), (i == TMO - 1) ? 32'd1 : 32'd0);
    end

    // Random traffic against the model
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
- Sits directly upstream of the decode stage and consumes the hazard unit's controls: PC_Write, PC_Mux_select, IF_ID_Stall and IF_ID_Flush.
- Drives the instruction-memory port with a ready handshake.
- Inserts bubbles on memory wait and flags a stuck memory with a watchdog.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, consecutive not-ready cycles before fetch_error sets (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
PC_Write  input  1  1 = PC may update this cycle
PC_Mux_select  input  2  00 sequential, 01 branch target, 10 jump target, 11 hold
IF_ID_Stall  input  1  1 = hold IF/ID contents
IF_ID_Flush  input  1  1 = load bubble into IF/ID
branch_target  input  32  branch redirect address
jump_target  input  32  jump redirect address
imem_addr  output  32  fetch address (= PC register)
imem_req  output  1  fetch request
imem_rdata  input  32  instruction, valid when imem_ready=1 for current imem_addr
imem_ready  input  1  fetch completes this cycle
IF_ID_PC  output  32  PC+4 of latched instruction
IF_ID_Instr  output  32  latched instruction
IF_ID_Valid  output  1  1 = IF/ID holds a real instruction
fetch_error  output  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: PC=RESET_PC, IF_ID_PC=0, IF_ID_Instr=0, IF_ID_Valid=0, fetch_error=0, wait counter=0, state=BOOT.
- Reset mid-operation discards the in-flight fetch and any pending IF/ID content.
- States:
  - BOOT: imem_req=0 for exactly one cycle after reset, then goes to RUN.
  - RUN: imem_req=1. imem_ready=0 -> WAIT. Otherwise stays in RUN.
  - WAIT: imem_req=1. imem_ready=1 -> RUN. Redirect -> RUN.
- Fetch completes (fc) when the state is RUN or WAIT and imem_ready=1.
- Next PC applies only when PC_Write=1; with PC_Write=0 the PC holds.
  - sel 00: PC+4 if fc, else PC.
  - sel 01: branch_target.
  - sel 10: jump_target.
  - sel 11: PC.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect (sel 01/10 with PC_Write=1) takes effect next cycle whatever imem_ready is. The in-flight fetch is abandoned, the wait counter clears and the state goes to RUN.
- IF/ID update priority, highest first:
  1. Flush: Valid=0, Instr=0, PC=0.
  2. Stall: all IF/ID fields hold.
  3. fc: Instr=imem_rdata, PC=imem_addr+4, Valid=1.
  4. Otherwise (not fc): bubble, Valid=0, Instr=0.
- Flush and stall asserted together: flush wins.
- Stall together with fc: the fetched word is dropped. The hazard unit keeps PC_Write=0 during a stall, so the word is refetched.
- Watchdog:
  - The counter increments each cycle in WAIT and clears on fc, on a redirect and on entering RUN.
  - When the counter reaches TIMEOUT, fetch_error=1. It stays set until rst.
  - The counter saturates at TIMEOUT.
- Latency: an instruction at PC=A with imem_ready=1 in cycle n appears on IF_ID_* in cycle n+1.

Optional Feature:
- Macro IF_STAGE_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0] and perf_wait_cnt[31:0].
  - perf_stall_cnt counts cycles with IF_ID_Stall=1 and IF_ID_Flush=0.
  - perf_flush_cnt counts cycles with IF_ID_Flush=1.
  - perf_wait_cnt counts WAIT cycles.
  - All three clear on rst and wrap at 2^32.
- When undefined, none of these ports or registers exist and the behaviour is otherwise identical.

Test Plan:
- Reset, imem_ready=1, PC_Write=1, sel=00, memory returns A0,A1,A2 -> imem_addr 0,4,8. Cycle after BOOT+1 shows IF_ID_Instr=A0, IF_ID_PC=4, IF_ID_Valid=1.
- Load-use stall: PC_Write=0 and IF_ID_Stall=1 for 1 cycle at PC=8 -> IF_ID holds the word from PC=4 and the PC stays 8. Next cycle loads the word at 8 with IF_ID_PC=12.
- Branch: sel=01, branch_target=0x40, PC_Write=1, IF_ID_Flush=1 -> IF_ID_Valid=0 next cycle and imem_addr=0x40. The following cycle shows IF_ID_PC=0x44.
- Memory wait: imem_ready low 3 cycles at PC=0x10 -> 3 bubbles (Valid=0) and the PC holds at 0x10. On ready=1 the word latches with IF_ID_PC=0x14.
- Watchdog: TIMEOUT=16, imem_ready held low 16 cycles -> fetch_error=1 after the 16th. It stays 1 after ready returns and clears only on rst.
- Stall and flush together, and a jump during WAIT (sel=10, jump_target=0x100) -> flush wins, the PC moves to 0x100, the state goes to RUN and the counter clears. With IF_STAGE_PERF_EN defined, perf_flush_cnt increments by 1.
